overworld_step_ctrl: RTL and testbench

// Tile-step movement sequencer for the overworld sprite datapath; active while the game FSM is in draw_main_game.

---
 rtl/overworld_step_ctrl_if.sv | 28 ++
 rtl/overworld_step_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_overworld_step_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/overworld_step_ctrl_if.sv
// Collision-lookup handshake between the step controller (master) and the
// shared map/collision block (slave).
interface overworld_step_ctrl_if #(
    parameter int XW = 6,
    parameter int YW = 6
);
    logic          blk_req;
    logic [XW-1:0] blk_x;
    logic [YW-1:0] blk_y;
    logic          blk_ack;
    logic          blk_solid;

    modport master (
        output blk_req,
        output blk_x,
        output blk_y,
        input  blk_ack,
        input  blk_solid
    );

    modport slave (
        input  blk_req,
        input  blk_x,
        input  blk_y,
        output blk_ack,
        output blk_solid
    );
endinterface

// File: rtl/overworld_step_ctrl.sv
// Tile-step movement sequencer for the overworld sprite. WASD keycodes become
// single-tile steps; each step is cleared with the collision block before the
// sprite walks, and all motion is paced on VGA frame ticks (rising VGA_VS).
module overworld_step_ctrl #(
    parameter int TILE_PX  = 16,
    parameter int MAP_W    = 64,
    parameter int MAP_H    = 64,
    parameter int START_X  = 8,
    parameter int START_Y  = 8,
    parameter int WALK_SPD = 1,
    parameter int RUN_SPD  = 2,
    parameter int TURN_FRM = 4,
    parameter int BUMP_FRM = 8,
    localparam int XW = $clog2(MAP_W),
    localparam int YW = $clog2(MAP_H),
    localparam int PW = $clog2(TILE_PX + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  VGA_VS,
    input  logic [7:0]            keycode,
    input  logic                  run_held,
    input  logic                  enable,
    overworld_step_ctrl_if.master blk,
    output logic [XW-1:0]         pos_x,
    output logic [YW-1:0]         pos_y,
    output logic [PW-1:0]         pix_off,
    output logic [1:0]            direction,
    output logic                  charIsMoving,
    output logic                  charIsRunning,
    output logic [1:0]            charMoveFrame,
    output logic                  step_done
);

    localparam int CW = $clog2(((TURN_FRM > BUMP_FRM) ? TURN_FRM : BUMP_FRM) + 1);

    localparam logic [XW:0]   LP_MAP_W   = (XW + 1)'(MAP_W);
    localparam logic [YW:0]   LP_MAP_H   = (YW + 1)'(MAP_H);
    localparam logic [PW-1:0] LP_TILE    = PW'(TILE_PX);
    localparam logic [PW-1:0] LP_HALF    = PW'(TILE_PX / 2);
    localparam logic [PW-1:0] LP_WALK    = PW'(WALK_SPD);
    localparam logic [PW-1:0] LP_RUN     = PW'(RUN_SPD);
    localparam logic [CW-1:0] LP_TURN_LS = CW'(TURN_FRM - 1);
    localparam logic [CW-1:0] LP_BUMP_LS = CW'(BUMP_FRM - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WALK  = 3'd3,
        ST_BUMP  = 3'd4
    } state_t;

    // Keycode decode: bit 2 = valid direction key, bits 1:0 = direction
    // (0 down, 1 up, 2 left, 3 right).
    function automatic logic [2:0] decode_key(input logic [7:0] k);
        logic [2:0] res;
        case (k)
            8'h1A:   res = 3'b101;
            8'h04:   res = 3'b110;
            8'h16:   res = 3'b100;
            8'h07:   res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    state_t        r_state;
    logic          r_vs_q;
    logic [XW-1:0] r_pos_x;
    logic [YW-1:0] r_pos_y;
    logic [PW-1:0] r_pix_off;
    logic [1:0]    r_dir;
    logic [CW-1:0] r_cnt;
    logic          r_run;
    logic          r_par;
    logic          r_blk_req;
    logic [XW-1:0] r_blk_x;
    logic [YW-1:0] r_blk_y;
    logic          r_moving;
    logic          r_running;
    logic [1:0]    r_anim;
    logic          r_done;

    state_t        w_nxt_state;
    logic [XW-1:0] w_nxt_pos_x;
    logic [YW-1:0] w_nxt_pos_y;
    logic [PW-1:0] w_nxt_pix;
    logic [1:0]    w_nxt_dir;
    logic [CW-1:0] w_nxt_cnt;
    logic          w_nxt_run;
    logic          w_nxt_par;
    logic          w_nxt_req;
    logic          w_nxt_done;
    logic [XW-1:0] w_nxt_blk_x;
    logic [YW-1:0] w_nxt_blk_y;
    logic          w_nxt_moving;
    logic          w_nxt_running;
    logic [1:0]    w_nxt_anim;

    logic          w_tick;
    logic [2:0]    w_key;
    logic [XW:0]   w_tx_ext;
    logic [YW:0]   w_ty_ext;
    logic          w_in_range;
    logic [PW-1:0] w_spd;
    logic [PW-1:0] w_sum;

    assign w_tick = VGA_VS & ~r_vs_q;
    assign w_key  = decode_key(keycode);
    assign w_spd  = r_run ? LP_RUN : LP_WALK;
    assign w_sum  = r_pix_off + w_spd;

    // Neighbouring tile in the facing direction, one bit wider so that
    // stepping off either map edge shows up as an out-of-range value.
    always_comb begin
        w_tx_ext = {1'b0, r_pos_x};
        w_ty_ext = {1'b0, r_pos_y};
        case (r_dir)
            2'd0:    w_ty_ext = {1'b0, r_pos_y} + {{YW{1'b0}}, 1'b1};
            2'd1:    w_ty_ext = {1'b0, r_pos_y} - {{YW{1'b0}}, 1'b1};
            2'd2:    w_tx_ext = {1'b0, r_pos_x} - {{XW{1'b0}}, 1'b1};
            2'd3:    w_tx_ext = {1'b0, r_pos_x} + {{XW{1'b0}}, 1'b1};
            default: w_tx_ext = {1'b0, r_pos_x};
        endcase
        w_in_range = (w_tx_ext < LP_MAP_W) && (w_ty_ext < LP_MAP_H);
    end

    // Next-state and next-output logic for the step sequencer.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_pos_x = r_pos_x;
        w_nxt_pos_y = r_pos_y;
        w_nxt_pix   = r_pix_off;
        w_nxt_dir   = r_dir;
        w_nxt_cnt   = r_cnt;
        w_nxt_run   = r_run;
        w_nxt_par   = r_par;
        w_nxt_req   = 1'b0;
        w_nxt_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && enable && w_key[2]) begin
                    if (w_key[1:0] != r_dir) begin
                        w_nxt_dir   = w_key[1:0];
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = ST_TURN;
                    end else begin
                        // Off-map targets skip the lookup entirely.
                        w_nxt_req   = w_in_range;
                        w_nxt_state = ST_CHECK;
                    end
                end else begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (w_tick) begin
                    if (r_cnt == LP_TURN_LS) begin
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_cnt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            ST_CHECK: begin
                if (!r_blk_req) begin
                    w_nxt_cnt   = {CW{1'b0}};
                    w_nxt_state = ST_BUMP;
                end else if (blk.blk_ack) begin
                    if (blk.blk_solid) begin
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = ST_BUMP;
                    end else begin
                        w_nxt_run   = run_held;
                        w_nxt_pix   = {PW{1'b0}};
                        w_nxt_state = ST_WALK;
                    end
                end else begin
                    // Hold the request until the collision block answers.
                    w_nxt_req = 1'b1;
                end
            end
            ST_WALK: begin
                if (w_tick) begin
                    if (w_sum == LP_TILE) begin
                        w_nxt_pos_x = w_tx_ext[XW-1:0];
                        w_nxt_pos_y = w_ty_ext[YW-1:0];
                        w_nxt_pix   = {PW{1'b0}};
                        w_nxt_done  = 1'b1;
                        w_nxt_par   = ~r_par;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_pix = w_sum;
                    end
                end else begin
                    w_nxt_pix = r_pix_off;
                end
            end
            ST_BUMP: begin
                if (w_tick) begin
                    if (r_cnt == LP_BUMP_LS) begin
                        w_nxt_cnt   = {CW{1'b0}};
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_cnt = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    w_nxt_cnt = r_cnt;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    // Pose and lookup-address values as they will appear after this edge.
    always_comb begin
        w_nxt_moving  = (w_nxt_state == ST_WALK);
        w_nxt_running = (w_nxt_state == ST_WALK) && w_nxt_run;
        if (w_nxt_state == ST_WALK) begin
            if (w_nxt_pix < LP_HALF) begin
                w_nxt_anim = 2'd1 + {1'b0, w_nxt_par};
            end else begin
                w_nxt_anim = 2'd0;
            end
        end else begin
            w_nxt_anim = 2'd0;
        end
        if (w_nxt_req) begin
            w_nxt_blk_x = w_tx_ext[XW-1:0];
            w_nxt_blk_y = w_ty_ext[YW-1:0];
        end else begin
            w_nxt_blk_x = w_nxt_pos_x;
            w_nxt_blk_y = w_nxt_pos_y;
        end
    end

    // State and registered-output update; Reset aborts any step in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_vs_q    <= 1'b1;
            r_pos_x   <= XW'(START_X);
            r_pos_y   <= YW'(START_Y);
            r_pix_off <= {PW{1'b0}};
            r_dir     <= 2'd0;
            r_cnt     <= {CW{1'b0}};
            r_run     <= 1'b0;
            r_par     <= 1'b0;
            r_blk_req <= 1'b0;
            r_blk_x   <= XW'(START_X);
            r_blk_y   <= YW'(START_Y);
            r_moving  <= 1'b0;
            r_running <= 1'b0;
            r_anim    <= 2'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_vs_q    <= VGA_VS;
            r_pos_x   <= w_nxt_pos_x;
            r_pos_y   <= w_nxt_pos_y;
            r_pix_off <= w_nxt_pix;
            r_dir     <= w_nxt_dir;
            r_cnt     <= w_nxt_cnt;
            r_run     <= w_nxt_run;
            r_par     <= w_nxt_par;
            r_blk_req <= w_nxt_req;
            r_blk_x   <= w_nxt_blk_x;
            r_blk_y   <= w_nxt_blk_y;
            r_moving  <= w_nxt_moving;
            r_running <= w_nxt_running;
            r_anim    <= w_nxt_anim;
            r_done    <= w_nxt_done;
        end
    end

    assign blk.blk_req   = r_blk_req;
    assign blk.blk_x     = r_blk_x;
    assign blk.blk_y     = r_blk_y;
    assign pos_x         = r_pos_x;
    assign pos_y         = r_pos_y;
    assign pix_off       = r_pix_off;
    assign direction     = r_dir;
    assign charIsMoving  = r_moving;
    assign charIsRunning = r_running;
    assign charMoveFrame = r_anim;
    assign step_done     = r_done;

endmodule

// File: tb/tb_overworld_step_ctrl.sv
// Directed bench for overworld_step_ctrl: reset, turn, walk, run, solid bump,
// map-edge bump, enable drop mid-step and reset mid-step.
module tb_overworld_step_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic       run_held;
    logic       enable;
    logic [5:0] pos_x;
    logic [5:0] pos_y;
    logic [4:0] pix_off;
    logic [1:0] direction;
    logic       charIsMoving;
    logic       charIsRunning;
    logic [1:0] charMoveFrame;
    logic       step_done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int req_cnt  = 0;
    int req_base;

    overworld_step_ctrl_if #(.XW(6), .YW(6)) bif ();

    overworld_step_ctrl dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .VGA_VS        (VGA_VS),
        .keycode       (keycode),
        .run_held      (run_held),
        .enable        (enable),
        .blk           (bif),
        .pos_x         (pos_x),
        .pos_y         (pos_y),
        .pix_off       (pix_off),
        .direction     (direction),
        .charIsMoving  (charIsMoving),
        .charIsRunning (charIsRunning),
        .charMoveFrame (charMoveFrame),
        .step_done     (step_done)
    );

    always #5 Clk = ~Clk;

    // Count step_done cycles and blk_req cycles for whole-run checks.
    always @(posedge Clk) begin
        if (step_done === 1'b1) done_cnt <= done_cnt + 1;
        if (bif.blk_req === 1'b1) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One frame tick; returns at the falling edge right after the tick edge.
    task automatic frame();
        @(negedge Clk) VGA_VS = 1'b0;
        @(negedge Clk) VGA_VS = 1'b1;
        @(negedge Clk);
    endtask

    // One-cycle grant from the collision block.
    task automatic ack(input logic solid, input logic run);
        bif.blk_ack   = 1'b1;
        bif.blk_solid = solid;
        run_held      = run;
        @(negedge Clk);
        bif.blk_ack   = 1'b0;
        bif.blk_solid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bif.blk_req !== 1'b1 && n < 40) begin
            frame();
            n++;
        end
        check(tag, 32'(bif.blk_req), 32'd1);
    endtask

    task automatic walk_step(input logic run, input string tag);
        int n = 0;
        logic found = 1'b0;
        wait_req({tag, "_req"});
        ack(1'b0, run);
        while (!found && n < 40) begin
            frame();
            if (step_done === 1'b1) found = 1'b1;
            n++;
        end
        check({tag, "_done"}, 32'(found), 32'd1);
    endtask

    initial begin
        Reset         = 1'b1;
        VGA_VS        = 1'b1;
        keycode       = 8'h00;
        run_held      = 1'b0;
        enable        = 1'b0;
        bif.blk_ack   = 1'b0;
        bif.blk_solid = 1'b0;
        repeat (3) @(negedge Clk);

        // Reset state
        check("rst_pos_x", 32'(pos_x), 32'd8);
        check("rst_pos_y", 32'(pos_y), 32'd8);
        check("rst_dir", 32'(direction), 32'd0);
        check("rst_pix", 32'(pix_off), 32'd0);
        check("rst_req", 32'(bif.blk_req), 32'd0);
        check("rst_blk_x", 32'(bif.blk_x), 32'd8);
        check("rst_blk_y", 32'(bif.blk_y), 32'd8);
        check("rst_moving", 32'(charIsMoving), 32'd0);
        check("rst_anim", 32'(charMoveFrame), 32'd0);
        check("rst_done", 32'(step_done), 32'd0);

        // VGA_VS high out of reset must not produce a tick
        Reset   = 1'b0;
        keycode = 8'h07;
        enable  = 1'b1;
        repeat (5) @(negedge Clk);
        check("no_spurious_tick", 32'(direction), 32'd0);

        // Turn right, then first walk step
        frame();
        check("t2_dir", 32'(direction), 32'd3);
        check("t2_turn_req", 32'(bif.blk_req), 32'd0);
        repeat (4) frame();
        check("t2_turn_len", 32'(bif.blk_req), 32'd0);
        frame();
        check("t2_req", 32'(bif.blk_req), 32'd1);
        check("t2_blk_x", 32'(bif.blk_x), 32'd9);
        check("t2_blk_y", 32'(bif.blk_y), 32'd8);
        @(negedge Clk);
        check("t2_req_hold", 32'(bif.blk_req), 32'd1);
        ack(1'b0, 1'b0);
        check("t2_req_drop", 32'(bif.blk_req), 32'd0);
        check("t2_moving", 32'(charIsMoving), 32'd1);
        check("t2_running", 32'(charIsRunning), 32'd0);
        check("t2_anim_a", 32'(charMoveFrame), 32'd1);
        repeat (7) frame();
        check("t2_pix7", 32'(pix_off), 32'd7);
        check("t2_anim_b", 32'(charMoveFrame), 32'd1);
        frame();
        check("t2_pix8", 32'(pix_off), 32'd8);
        check("t2_anim_c", 32'(charMoveFrame), 32'd0);
        repeat (7) frame();
        check("t2_pix15", 32'(pix_off), 32'd15);
        check("t2_pos_mid", 32'(pos_x), 32'd8);
        check("t2_done_early", 32'(step_done), 32'd0);
        frame();
        check("t2_pos_x", 32'(pos_x), 32'd9);
        check("t2_pix0", 32'(pix_off), 32'd0);
        check("t2_done", 32'(step_done), 32'd1);
        check("t2_idle", 32'(charIsMoving), 32'd0);
        @(negedge Clk);
        check("t2_done_pulse", 32'(step_done), 32'd0);
        check("t2_done_cnt", 32'(done_cnt), 32'd1);

        // Running step
        frame();
        check("t3_req", 32'(bif.blk_req), 32'd1);
        check("t3_blk_x", 32'(bif.blk_x), 32'd10);
        ack(1'b0, 1'b1);
        check("t3_running", 32'(charIsRunning), 32'd1);
        check("t3_anim_a", 32'(charMoveFrame), 32'd2);
        repeat (3) frame();
        check("t3_pix6", 32'(pix_off), 32'd6);
        frame();
        check("t3_pix8", 32'(pix_off), 32'd8);
        check("t3_anim_b", 32'(charMoveFrame), 32'd0);
        repeat (3) frame();
        check("t3_pix14", 32'(pix_off), 32'd14);
        check("t3_running_late", 32'(charIsRunning), 32'd1);
        check("t3_pos_mid", 32'(pos_x), 32'd9);
        frame();
        check("t3_pos_x", 32'(pos_x), 32'd10);
        check("t3_done", 32'(step_done), 32'd1);
        check("t3_run_off", 32'(charIsRunning), 32'd0);

        // Solid target -> bump
        frame();
        check("t4_req", 32'(bif.blk_req), 32'd1);
        check("t4_blk_x", 32'(bif.blk_x), 32'd11);
        ack(1'b1, 1'b0);
        check("t4_req_drop", 32'(bif.blk_req), 32'd0);
        check("t4_moving", 32'(charIsMoving), 32'd0);
        check("t4_pos_x", 32'(pos_x), 32'd10);
        check("t4_pix", 32'(pix_off), 32'd0);
        repeat (8) frame();
        check("t4_bump_len", 32'(bif.blk_req), 32'd0);
        check("t4_pos_hold", 32'(pos_x), 32'd10);
        frame();
        check("t4_req_again", 32'(bif.blk_req), 32'd1);
        ack(1'b1, 1'b0);

        // Walk up to the top edge, running
        keycode = 8'h1A;
        for (int i = 0; i < 8; i++) walk_step(1'b1, "t5_walk");
        check("t5_pos_y", 32'(pos_y), 32'd0);
        check("t5_pos_x", 32'(pos_x), 32'd10);
        check("t5_dir", 32'(direction), 32'd1);

        // Off-map target: no lookup, bump, position unchanged
        req_base = req_cnt;
        repeat (20) frame();
        check("t5_no_req", 32'(req_cnt - req_base), 32'd0);
        check("t5_pos_y_hold", 32'(pos_y), 32'd0);
        check("t5_moving", 32'(charIsMoving), 32'd0);

        // enable dropped mid-step: step still finishes
        keycode = 8'h07;
        wait_req("t6_req");
        check("t6_blk_x", 32'(bif.blk_x), 32'd11);
        ack(1'b0, 1'b0);
        repeat (5) frame();
        check("t6_pix5", 32'(pix_off), 32'd5);
        enable = 1'b0;
        repeat (11) frame();
        check("t6_pos_x", 32'(pos_x), 32'd11);
        check("t6_done", 32'(step_done), 32'd1);
        req_base = req_cnt;
        repeat (10) frame();
        check("t6_blocked", 32'(req_cnt - req_base), 32'd0);
        check("t6_pos_hold", 32'(pos_x), 32'd11);

        // Reset mid-step
        enable = 1'b1;
        wait_req("t6r_req");
        ack(1'b0, 1'b0);
        repeat (5) frame();
        check("t6r_pix5", 32'(pix_off), 32'd5);
        Reset = 1'b1;
        @(negedge Clk);
        check("t6r_pos_x", 32'(pos_x), 32'd8);
        check("t6r_pos_y", 32'(pos_y), 32'd8);
        check("t6r_pix", 32'(pix_off), 32'd0);
        check("t6r_dir", 32'(direction), 32'd0);
        check("t6r_moving", 32'(charIsMoving), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        check("total_steps", 32'(done_cnt), 32'd11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
